// File: rtl/vrf_read_pkg.sv
// Shared types and widths for the VRF read-request responder.
package vrf_read_pkg;

  localparam int VS_W   = 5;
  localparam int SRC_W  = 4;
  localparam int INST_W = 3;

  // Tag carried alongside a read from acceptance to response
  typedef struct packed {
    logic [SRC_W-1:0]  readSource;
    logic [INST_W-1:0] instructionIndex;
  } read_tag_t;

  localparam int TAG_W = SRC_W + INST_W;

endpackage

// File: rtl/vrf_read_resp_fifo.sv
// In-order response queue: circular buffer with read/write pointers and an
// occupancy count. Storage is cleared on reset so the head reads as zero.
module vrf_read_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 39
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage write at the tail
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credits upstream make an overflowing push impossible; flag it if it happens
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(push && full))
        else $error("vrf_read_resp_fifo: push while full");
    end
  end

endmodule

// File: rtl/vrf_read_responder.sv
// Responder end of the VRF read-request channel. Accepted requests strobe the
// register-file SRAM, their tags ride a fixed-latency shift pipeline alongside
// the SRAM access, and data+tag land in an in-order response queue. A credit
// count covering in-flight reads plus queued responses gates req_ready, so the
// pipeline never stalls and SRAM data is never dropped.
module vrf_read_responder
  import vrf_read_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 2,
  parameter int RESP_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              req_ready,
  input  logic              req_valid,
  input  logic [VS_W-1:0]   req_bits_vs,
  input  logic [SRC_W-1:0]  req_bits_readSource,
  input  logic [INST_W-1:0] req_bits_instructionIndex,
  output logic              ram_rd_en,
  output logic [VS_W-1:0]   ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_bits_data,
  output logic [SRC_W-1:0]  resp_bits_readSource,
  output logic [INST_W-1:0] resp_bits_instructionIndex
);

  localparam int USED_W  = $clog2(RESP_DEPTH + 1);
  localparam int ENTRY_W = DATA_W + TAG_W;
  localparam logic [USED_W-1:0] USED_MAX = USED_W'(RESP_DEPTH);

  logic [USED_W-1:0]      used_q;
  logic                   req_fire;
  logic                   resp_fire;
  read_tag_t              req_tag;
  logic [RAM_LATENCY-1:0] vld_p;
  read_tag_t              tag_p [RAM_LATENCY];
  logic [ENTRY_W-1:0]     push_entry;
  logic [ENTRY_W-1:0]     head_entry;
  logic                   fifo_empty;
  read_tag_t              head_tag;

  // A credit is returned by a pop only in the following cycle, so sustained
  // one-per-cycle acceptance needs RESP_DEPTH >= RAM_LATENCY+2.
  assign req_ready   = (used_q < USED_MAX);
  assign req_fire    = req_valid & req_ready;
  assign req_tag     = {req_bits_readSource, req_bits_instructionIndex};

  assign ram_rd_en   = req_fire;
  assign ram_rd_addr = req_bits_vs;

  // Credit counter: +1 per accepted request, -1 per delivered response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      used_q <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   used_q <= used_q + 1'b1;
        2'b01:   used_q <= used_q - 1'b1;
        default: used_q <= used_q;
      endcase
    end
  end

  // Stage 0 .. RAM_LATENCY-1: tag shift pipeline matched to SRAM latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) tag_p[i] <= '0;
    end else begin
      vld_p[0] <= req_fire;
      tag_p[0] <= req_tag;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  // Final stage: SRAM data joins its tag and enters the response queue
  assign push_entry = {ram_rd_data, tag_p[RAM_LATENCY-1]};

  vrf_read_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (vld_p[RAM_LATENCY-1]),
    .push_data (push_entry),
    .pop       (resp_fire),
    .head_data (head_entry),
    .empty     (fifo_empty)
  );

  assign resp_valid                 = ~fifo_empty;
  assign resp_fire                  = resp_valid & resp_ready;
  assign head_tag                   = head_entry[TAG_W-1:0];
  assign resp_bits_data             = head_entry[ENTRY_W-1:TAG_W];
  assign resp_bits_readSource       = head_tag.readSource;
  assign resp_bits_instructionIndex = head_tag.instructionIndex;

endmodule
